tdm_demux4: RTL
===============

# tdm_demux4

Four-channel time-division demultiplexer: the receive end of the 4:1 select-based multiplexer path. Takes one serial sample stream with a frame-sync marker on channel 0 and steers each valid sample to one of four registered channel outputs via an internal slot counter. Also assembles complete frames into an atomically updated frame register for downstream consumers. Sits between the serial link and per-channel processing.

## Interface
- W, 1, sample width in bits
- MISS_MAX, 2, consecutive frames with missing sync before lock is dropped (1..7)

- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- din  input  W  serial sample
- din_valid  input  1  din carries a sample this cycle
- frame_sync  input  1  qualifies current valid sample as channel 0; ignored when din_valid=0
- ip0..ip3  output  W each  last sample captured for channel 0..3; hold value between updates
- ch_valid  output  4  one-hot one-cycle strobe, bit n set in the cycle ip<n> updates
- sel  output  2  slot assigned to the next valid sample
- frame  output  4*W  {ch3,ch2,ch1,ch0} of last complete frame
- frame_done  output  1  one-cycle pulse in the cycle frame updates
- locked  output  1  state is LOCKED
- sync_err  output  1  one-cycle pulse on an out-of-place sync

## Operation
- States: HUNT, LOCKED. Reset -> HUNT, slot=0, miss count=0.
- HUNT: valid samples without sync discarded (no strobes). Valid sample with sync -> captured as slot 0, slot=1, go LOCKED.
- LOCKED, valid sample: written to ip<slot> and shadow[slot]; ch_valid[slot] pulses; slot increments mod 4 (3 wraps to 0).
- Slot 3 capture: frame <= {din, shadow[2], shadow[1], shadow[0]}; frame_done pulses.
- Sync on a sample with slot=0: normal, miss count cleared.
- Sync on a sample with slot≠0: sync_err pulses; sample treated as slot 0 (ip0 updated, slot=1); partial frame discarded, no frame_done; miss count cleared.
- Sample at slot 0 without sync: captured normally; miss count +1. Reaching MISS_MAX -> go HUNT, slot=0, sample still captured to ip0.
- din_valid=0: no state, slot, or output change except strobes deassert.
- Frame shadow for slots 0..2 is not cleared on sync_err; overwritten by new frame.

## Timing
- All outputs registered. Sample at edge k appears on ip<n>/ch_valid at edge k+1 (latency 1).
- frame/frame_done: same edge as slot-3 ip3 update.
- sel reflects slot after the update; combinationally stable for whole cycle.
- Reset values: ip0..ip3=0, ch_valid=0, sel=0, frame=0, frame_done=0, locked=0, sync_err=0.
- Reset asserted mid-frame: immediate clear, partial frame lost; first sample after release needs sync.
- Back-to-back valid samples sustained every cycle; throughput 1 sample/cycle.

## Structure
- Package tdm_pkg: NUM_CH=4, SLOT_W=2, state enum {HUNT, LOCKED}.
- Sub-module tdm_slot_counter: 2-bit wrapping counter with sync-load-to-1, advance on valid, clear on reset; exports slot.
- Top holds FSM, miss counter (3 bits), channel/shadow/frame registers.

## Test plan
- Reset, then din=1,0,1,1 valid every cycle with sync on first -> ch_valid 0001,0010,0100,1000; frame=4'b1101; frame_done on 4th output cycle; locked=1.
- Samples without sync after reset -> no ch_valid, locked=0, ip0..ip3 stay 0.
- Locked, sync on slot 2 sample -> sync_err pulse, ip0 updates, ch_valid=0001, sel=1, no frame_done for interrupted frame.
- Locked, MISS_MAX=2, two frames with no sync -> locked drops at second slot-0 sample; next unsynced samples ignored.
- din_valid toggling 1,0,1,0 over a frame -> slot advances only on valid; frame_done after 4th valid sample.
- rst pulsed after slot 2 -> all outputs 0 asynchronously; resync frame assembles correctly from slot 0.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the four-channel TDM demultiplexer.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Two-bit wrapping slot counter. A sync load forces slot 1, because the sample
// carrying the sync is itself consumed as slot 0. A clear returns the counter
// to slot 0, and an advance steps it forward on each accepted sample.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  advance,
  input  logic  load_one,
  input  logic  clear,
  output slot_t slot
);

  // Slot register. A sync load takes priority over a clear, and a clear takes
  // priority over a normal advance.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (load_one) begin
      slot <= slot_t'(1);
    end else if (clear) begin
      slot <= '0;
    end else if (advance) begin
      slot <= slot + slot_t'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer. It hunts for a frame sync, then steers each
// valid sample to its channel register. Complete frames are published
// atomically on the frame output. Lock is dropped after MISS_MAX consecutive
// frames whose slot-0 sample arrives without a sync.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W        = 1,
  parameter int MISS_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [W-1:0]      ip0,
  output logic [W-1:0]      ip1,
  output logic [W-1:0]      ip2,
  output logic [W-1:0]      ip3,
  output logic [NUM_CH-1:0] ch_valid,
  output logic [1:0]        sel,
  output logic [4*W-1:0]    frame,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  state_t      state;
  logic [2:0]  miss_cnt;
  logic [2:0]  miss_next;
  slot_t       slot;
  slot_t       tgt;
  logic        take;
  logic        load_one;
  logic        clear;
  logic        advance;
  logic        err;
  logic        drop;
  logic [NUM_CH-1:0] onehot;
  logic [W-1:0] ch_q   [NUM_CH];
  logic [W-1:0] shadow [NUM_CH-1];

  tdm_slot_counter u_slot (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance),
    .load_one (load_one),
    .clear    (clear),
    .slot     (slot)
  );

  // Decide what happens to the sample offered this cycle: which slot takes it,
  // how the slot counter moves, and whether lock is gained, kept or lost.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    take      = 1'b0;
    tgt       = slot;
    load_one  = 1'b0;
    clear     = 1'b0;
    advance   = 1'b0;
    err       = 1'b0;
    drop      = 1'b0;
    miss_next = miss_cnt;
    if (din_valid) begin
      if (state == HUNT) begin
        if (frame_sync) begin
          take      = 1'b1;
          tgt       = '0;
          load_one  = 1'b1;
          miss_next = '0;
        end
      end else begin
        take = 1'b1;
        if (frame_sync) begin
          // A sync always realigns to slot 0. When the counter disagrees, the
          // partial frame is abandoned and the mismatch is flagged.
          tgt       = '0;
          load_one  = 1'b1;
          miss_next = '0;
          err       = (slot != '0);
        end else begin
          advance = 1'b1;
          if (slot == '0) begin
            miss_next = miss_cnt + 3'd1;
            if (miss_next >= 3'(MISS_MAX)) begin
              drop      = 1'b1;
              clear     = 1'b1;
              advance   = 1'b0;
              miss_next = '0;
            end
          end
        end
      end
    end
    onehot      = '0;
    onehot[tgt] = take;
  end

  // FSM, miss counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      miss_cnt   <= '0;
      ch_valid   <= '0;
      frame      <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
    end else begin
      ch_valid   <= onehot;
      sync_err   <= err;
      frame_done <= take && (tgt == slot_t'(NUM_CH - 1));
      miss_cnt   <= miss_next;
      if (take) ch_q[tgt] <= din;
      if (take && (tgt == slot_t'(NUM_CH - 1)))
        frame <= {din, shadow[2], shadow[1], shadow[0]};
      if (load_one) state <= LOCKED;
      else if (drop) state <= HUNT;
    end
  end

  // Frame shadow for slots 0..2. Slot 3 is reachable only after slots 0, 1 and
  // 2 have been written in order, so the shadow never publishes stale data.
  // NOTE: this storage deliberately has no reset; every entry is overwritten
  // before any read can observe it.
  always_ff @(posedge clk) begin
    if (take && (tgt != slot_t'(NUM_CH - 1))) shadow[tgt] <= din;
  end

  assign ip0    = ch_q[0];
  assign ip1    = ch_q[1];
  assign ip2    = ch_q[2];
  assign ip3    = ch_q[3];
  assign sel    = slot;
  assign locked = (state == LOCKED);

endmodule
